// File: rtl/jpeg_byte_packer_if.sv
// Bundle between the entropy coder, the byte packer and the downstream byte consumer.
// The master side drives the word strobe, frame end and byte_ready; the slave side is the packer.
interface jpeg_byte_packer_if #(
    parameter int CNT_W = 20
);
    logic             jpg_en;
    logic [31:0]      jpg_out;
    logic             frame_end;
    logic             in_full;
    logic             overflow;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic             frame_done;
    logic [CNT_W-1:0] byte_count;

    modport master (
        output jpg_en, jpg_out, frame_end, byte_ready,
        input  in_full, overflow, byte_out, byte_valid, frame_done, byte_count
    );

    modport slave (
        input  jpg_en, jpg_out, frame_end, byte_ready,
        output in_full, overflow, byte_out, byte_valid, frame_done, byte_count
    );
endinterface

// File: rtl/jpeg_byte_packer.sv
// Buffers 32-bit entropy-coder words and emits them MSB-first as a 0xFF-stuffed byte stream.
// Define JPEG_EOI_EN to append the unstuffed FF D9 end-of-image marker to every frame.
module jpeg_byte_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 20
) (
    input logic               clock,
    input logic               reset,
    jpeg_byte_packer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        STUFF,
`ifdef JPEG_EOI_EN
        EOI_FF,
        EOI_D9,
`endif
        DONE
    } state_t;

`ifdef JPEG_EOI_EN
    localparam state_t FIN = EOI_FF;
`else
    localparam state_t FIN = DONE;
`endif

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_empty, wr_en, pop;

    state_t           state, state_n;
    logic [31:0]      word, word_n;
    logic [1:0]       idx, idx_n;
    logic             pending, pend_eff, accept, adv;
    logic             valid_q, ovf, restart;
    logic [7:0]       byte_q;
    logic [CNT_W-1:0] cnt;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [7:0] present(input state_t s, input logic [31:0] w, input logic [1:0] i);
        case (s)
            SEND:    return sel_byte(w, i);
`ifdef JPEG_EOI_EN
            EOI_FF:  return 8'hFF;
            EOI_D9:  return 8'hD9;
`endif
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic presents(input state_t s);
`ifdef JPEG_EOI_EN
        return (s == SEND) || (s == STUFF) || (s == EOI_FF) || (s == EOI_D9);
`else
        return (s == SEND) || (s == STUFF);
`endif
    endfunction

    assign bus.in_full    = (count == (AW+1)'(FIFO_DEPTH));
    assign bus.overflow   = ovf;
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.frame_done = (state == DONE);
    assign bus.byte_count = cnt;

    assign fifo_empty = (count == '0);
    assign wr_en      = bus.jpg_en && !bus.in_full;
    // A word strobed alongside frame_end still belongs to the frame, so drain waits for it.
    assign pend_eff   = pending || bus.frame_end;
    assign accept     = valid_q && bus.byte_ready;

    always_comb begin
        state_n = state;
        word_n  = word;
        idx_n   = idx;
        pop     = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_n  = mem[rd_ptr];
                    idx_n   = 2'd0;
                    state_n = SEND;
                end else if (pend_eff && !wr_en) begin
                    state_n = FIN;
                end
            end
            SEND: begin
                if (accept) begin
                    if (sel_byte(word, idx) == 8'hFF) state_n = STUFF;
                    else                              adv     = 1'b1;
                end
            end
            STUFF: if (accept) adv = 1'b1;
`ifdef JPEG_EOI_EN
            EOI_FF: if (accept) state_n = EOI_D9;
            EOI_D9: if (accept) state_n = DONE;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Chain straight into the next word (or the frame tail) so no bubble cycle appears.
        if (adv) begin
            if (idx != 2'd3) begin
                idx_n   = idx + 2'd1;
                state_n = SEND;
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                word_n  = mem[rd_ptr];
                idx_n   = 2'd0;
                state_n = SEND;
            end else if (pend_eff && !wr_en) begin
                state_n = FIN;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= 1'b0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
            cnt     <= '0;
            restart <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pending <= bus.frame_end || (pending && (state != DONE));
            if (bus.jpg_en && bus.in_full) ovf <= 1'b1;
            valid_q <= presents(state_n);
            byte_q  <= present(state_n, word_n, idx_n);
            if (state == DONE) restart <= 1'b1;
            if (accept) begin
                if (restart) begin
                    cnt     <= CNT_W'(1);
                    restart <= 1'b0;
                end else if (!(&cnt)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= bus.jpg_out;
        word <= word_n;
    end
endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Directed bench for jpeg_byte_packer: stuffing, EOI, backpressure, overflow, frames, reset.
module tb_jpeg_byte_packer;
`ifdef JPEG_EOI_EN
    localparam int EOI_N = 2;
`else
    localparam int EOI_N = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    jpeg_byte_packer_if #(.CNT_W(20)) bus ();
    jpeg_byte_packer #(.FIFO_DEPTH(8), .CNT_W(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got  [$];
    logic [7:0] want [$];
    int   done_cnt = 0;
    int   stab_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.byte_valid || bus.byte_out !== prev_byte)) stab_err++;
            if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
            if (bus.frame_done) done_cnt++;
            prev_stall = bus.byte_valid && !bus.byte_ready;
            prev_byte  = bus.byte_out;
        end
    end

    function automatic void add_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            logic [7:0] b;
            b = w[8*k +: 8];
            want.push_back(b);
            if (b == 8'hFF) want.push_back(8'h00);
        end
    endfunction

    function automatic void add_eoi();
`ifdef JPEG_EOI_EN
        want.push_back(8'hFF);
        want.push_back(8'hD9);
`endif
    endfunction

    function automatic int seq_diff();
        int d;
        int n;
        d = (got.size() != want.size()) ? 1 : 0;
        n = (got.size() < want.size()) ? got.size() : want.size();
        for (int k = 0; k < n; k++) if (got[k] !== want[k]) d++;
        return d;
    endfunction

    task automatic send_word(input logic [31:0] w, input logic fe);
        bus.jpg_en    = 1'b1;
        bus.jpg_out   = w;
        bus.frame_end = fe;
        @(posedge clock); #1;
        bus.jpg_en    = 1'b0;
        bus.frame_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (bus.in_full !== 1'b0)    begin n_bad++; $display("FAIL rst_in_full got %b want 0", bus.in_full); end
        n_cmp++; if (bus.overflow !== 1'b0)   begin n_bad++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.byte_out !== 8'h00)  begin n_bad++; $display("FAIL rst_byte_out got %h want 00", bus.byte_out); end
        n_cmp++; if (bus.byte_valid !== 1'b0) begin n_bad++; $display("FAIL rst_byte_valid got %b want 0", bus.byte_valid); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
        n_cmp++; if (bus.byte_count !== 20'd0) begin n_bad++; $display("FAIL rst_byte_count got %0d want 0", bus.byte_count); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_word();
        int d0;
        int d;
        d0 = done_cnt;
        got.delete(); want.delete();
        add_word(32'h12FF3456); add_eoi();
        send_word(32'h12FF3456, 1'b1);
        @(negedge clock);
        n_cmp++; if (bus.byte_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early_valid got %b want 0", bus.byte_valid); end
        @(negedge clock);
        n_cmp++; if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h12)
            begin n_bad++; $display("FAIL lat_first_byte got v=%b %h want v=1 12", bus.byte_valid, bus.byte_out); end
        repeat (5 + EOI_N) @(negedge clock);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL single_done_cycle got %b want 1", bus.frame_done); end
        repeat (4) @(posedge clock);
        #1;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL single_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.byte_count !== 20'(5 + EOI_N)) begin n_bad++; $display("FAIL single_count got %0d want %0d", bus.byte_count, 5 + EOI_N); end
    endtask

    task automatic test_all_ff();
        int d0;
        int d;
        d0 = done_cnt;
        got.delete(); want.delete();
        add_word(32'hFFFFFFFF); add_eoi();
        send_word(32'hFFFFFFFF, 1'b1);
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clock);
        #1;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL allff_done got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL allff_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.byte_count !== 20'(8 + EOI_N)) begin n_bad++; $display("FAIL allff_count got %0d want %0d", bus.byte_count, 8 + EOI_N); end
    endtask

    task automatic test_backpressure();
        int d0;
        int d;
        logic [31:0] words [32];
        d0 = done_cnt;
        got.delete(); want.delete();
        stab_err = 0;
        for (int i = 0; i < 32; i++) begin
            words[i] = $urandom;
            if (i % 4 == 0) words[i][15:8] = 8'hFF;
            if (i % 7 == 0) words[i][31:24] = 8'hFF;
            add_word(words[i]);
        end
        add_eoi();
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    for (int w = 0; w < 500 && bus.in_full; w++) begin @(posedge clock); #1; end
                    send_word(words[i], i == 31);
                end
            end
            begin
                for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
                    bus.byte_ready = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                end
                bus.byte_ready = 1'b1;
            end
        join
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL bp_done got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL bp_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL bp_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.byte_count !== 20'(want.size())) begin n_bad++; $display("FAIL bp_count got %0d want %0d", bus.byte_count, want.size()); end
    endtask

    task automatic test_overflow();
        int d0;
        int d;
        d0 = done_cnt;
        got.delete(); want.delete();
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin n_cmp++; if (bus.in_full !== 1'b0) begin n_bad++; $display("FAIL ovf_not_full got %b want 0", bus.in_full); end end
            if (i == 9) begin n_cmp++; if (bus.in_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", bus.in_full); end end
            if (i < 9) add_word(32'h01020304 + 32'(i) * 32'h10101010);
            bus.jpg_en  = 1'b1;
            bus.jpg_out = 32'h01020304 + 32'(i) * 32'h10101010;
            @(posedge clock); #1;
        end
        bus.jpg_en = 1'b0;
        add_eoi();
        @(negedge clock);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        @(posedge clock); #1;
        bus.byte_ready = 1'b1;
        bus.frame_end  = 1'b1;
        @(posedge clock); #1;
        bus.frame_end  = 1'b0;
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(posedge clock);
        #1;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL ovf_done got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL ovf_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    endtask

    task automatic test_multi_frame();
        int d0;
        int d;
        d0 = done_cnt;
        got.delete(); want.delete();
        add_word(32'h11223344); add_word(32'h55667788); add_word(32'h99AABBCC); add_eoi();
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b0);
        send_word(32'h99AABBCC, 1'b1);
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL mf_a_done got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL mf_a_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.byte_count !== 20'(12 + EOI_N)) begin n_bad++; $display("FAIL mf_a_count got %0d want %0d", bus.byte_count, 12 + EOI_N); end
        d0 = done_cnt;
        got.delete(); want.delete();
        add_word(32'hA1B2C3D4); add_eoi();
        send_word(32'hA1B2C3D4, 1'b1);
        repeat (2) @(negedge clock);
        n_cmp++; if (bus.byte_count !== 20'(12 + EOI_N)) begin n_bad++; $display("FAIL mf_hold_count got %0d want %0d", bus.byte_count, 12 + EOI_N); end
        @(negedge clock);
        n_cmp++; if (bus.byte_count !== 20'd1) begin n_bad++; $display("FAIL mf_restart_count got %0d want 1", bus.byte_count); end
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clock);
        #1;
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL mf_b_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.byte_count !== 20'(4 + EOI_N)) begin n_bad++; $display("FAIL mf_b_count got %0d want %0d", bus.byte_count, 4 + EOI_N); end
    endtask

    task automatic test_reset_mid();
        int d0;
        int d;
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'h0A0B0C0D, 1'b0);
        send_word(32'h01010101, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.byte_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_valid got %b want 0", bus.byte_valid); end
        n_cmp++; if (bus.byte_out !== 8'h00)   begin n_bad++; $display("FAIL mid_byte_out got %h want 00", bus.byte_out); end
        n_cmp++; if (bus.overflow !== 1'b0)    begin n_bad++; $display("FAIL mid_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.byte_count !== 20'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", bus.byte_count); end
        n_cmp++; if (bus.frame_done !== 1'b0 || bus.in_full !== 1'b0)
            begin n_bad++; $display("FAIL mid_flags got done=%b full=%b want 0 0", bus.frame_done, bus.in_full); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        d0 = done_cnt;
        got.delete(); want.delete();
        add_word(32'hCAFE0102); add_eoi();
        send_word(32'hCAFE0102, 1'b1);
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL mid_done got %0d want 1", done_cnt - d0); end
        d = seq_diff();
        n_cmp++; if (d != 0) begin n_bad++; $display("FAIL mid_bytes diffs %0d got len %0d want len %0d", d, got.size(), want.size()); end
        n_cmp++; if (bus.byte_count !== 20'(4 + EOI_N)) begin n_bad++; $display("FAIL mid_final_count got %0d want %0d", bus.byte_count, 4 + EOI_N); end
    endtask

    initial begin
        bus.jpg_en     = 1'b0;
        bus.jpg_out    = 32'h0;
        bus.frame_end  = 1'b0;
        bus.byte_ready = 1'b1;
        test_reset();
        test_single_word();
        test_all_ff();
        test_backpressure();
        test_overflow();
        test_multi_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
